// File: rtl/lsu_req_ctrl.sv
// RV32I load/store request controller driving a single-beat LSU bus.
// Optional WAIT timeout is built only when LSU_REQ_TIMEOUT_EN is defined.
module lsu_req_ctrl #(
    parameter int TIMEOUT_CYC = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic        i_req_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_rsp_vld,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_err,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    output logic        o_lsu_wren,
    input  logic [31:0] i_ld_data,
    input  logic        i_data_vld
);

    // state | meaning
    // IDLE  | ready for a request; errors are answered from here
    // ISSUE | single bus cycle; stores complete here
    // WAIT  | load issued, waiting for registered LSU valid
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic        tmo_hit;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic r;
        if (we) r = (f3 > 3'd2);
        else    r = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return r;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic r;
        r = 1'b0;
        case (f3[1:0])
            2'b01:   r = a[0];
            2'b10:   r = (a != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ld_extract(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (f3)
            3'd0:    r = {{24{w[7]}}, w[7:0]};
            3'd1:    r = {{16{w[15]}}, w[15:0]};
            3'd2:    r = w;
            3'd4:    r = {24'd0, w[7:0]};
            3'd5:    r = {16'd0, w[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [31:0] ld_shifted;
    assign ld_shifted = i_ld_data >> {addr_q[1:0], 3'b000};

`ifdef LSU_REQ_TIMEOUT_EN
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counter only runs in WAIT, so it self-clears on every exit.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_WAIT && !i_data_vld && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    tmo_param_ok: assert property (@(posedge i_clk) TIMEOUT_CYC >= 2);

    assign o_req_rdy = (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_vld_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = ERR_OK;

        case (state_q)
            S_IDLE: begin
                if (i_req_vld) begin
                    we_d     = i_req_we;
                    funct3_d = i_funct3;
                    addr_d   = i_addr;
                    wdata_d  = i_wdata;
                    if (f3_illegal(i_req_we, i_funct3)) begin
                        rsp_vld_d = 1'b1;
                        rsp_err_d = ERR_ILL;
                    end else if (f3_misaligned(i_funct3, i_addr[1:0])) begin
                        rsp_vld_d = 1'b1;
                        rsp_err_d = ERR_MISAL;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // i_data_vld here still reflects the idle address 0.
                if (we_q) begin
                    state_d   = S_IDLE;
                    rsp_vld_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_data_vld) begin
                    state_d     = S_IDLE;
                    rsp_vld_d   = 1'b1;
                    rsp_rdata_d = ld_extract(funct3_q, ld_shifted);
                end else if (tmo_hit) begin
                    state_d   = S_IDLE;
                    rsp_vld_d = 1'b1;
`ifdef LSU_REQ_TIMEOUT_EN
                    rsp_err_d = ERR_TMO;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_lsu_addr = '0;
        o_st_data  = '0;
        o_st_strb  = '0;
        o_lsu_wren = 1'b0;
        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            o_lsu_addr = {addr_q[31:2], 2'b00};
        end
        if (state_q == S_ISSUE && we_q) begin
            o_lsu_wren = 1'b1;
            case (funct3_q[1:0])
                2'b00: begin
                    o_st_strb = 4'b0001 << addr_q[1:0];
                    o_st_data = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    o_st_strb = 4'b0011 << addr_q[1:0];
                    o_st_data = {2{wdata_q[15:0]}};
                end
                default: begin
                    o_st_strb = 4'hF;
                    o_st_data = wdata_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_rsp_vld   = rsp_vld_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Directed bench for lsu_req_ctrl: vector table plus reset, timeout and back-to-back sequences.
module tb_lsu_req_ctrl;

    localparam int TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_vld = 1'b0;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] i_ld_data = '0;
    logic        i_data_vld = 1'b0;
    logic        o_req_rdy;
    logic        o_rsp_vld;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_err;
    logic [31:0] o_lsu_addr;
    logic [31:0] o_st_data;
    logic [3:0]  o_st_strb;
    logic        o_lsu_wren;

    lsu_req_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_vld  (i_req_vld),
        .o_req_rdy  (o_req_rdy),
        .i_req_we   (i_req_we),
        .i_funct3   (i_funct3),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rsp_vld  (o_rsp_vld),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err  (o_rsp_err),
        .o_lsu_addr (o_lsu_addr),
        .o_st_data  (o_st_data),
        .o_st_strb  (o_st_strb),
        .o_lsu_wren (o_lsu_wren),
        .i_ld_data  (i_ld_data),
        .i_data_vld (i_data_vld)
    );

    always #5 i_clk = ~i_clk;

    // Registered LSU model: answers a load address after model_dly extra cycles.
    bit          model_en = 1'b0;
    int          model_dly = 0;
    logic [31:0] model_data = '0;
    int          pres_cnt = 0;

    always @(posedge i_clk) begin
        if (model_en && o_lsu_addr != 32'd0 && !o_lsu_wren) begin
            i_data_vld <= (pres_cnt >= model_dly);
            i_ld_data  <= model_data;
            pres_cnt   <= pres_cnt + 1;
        end else begin
            i_data_vld <= 1'b0;
            pres_cnt   <= 0;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        int          dly;
        int          lat;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [31:0] baddr;
        logic [3:0]  strb;
        logic [31:0] sdata;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        i_req_vld = 1'b1;
        i_req_we  = we;
        i_funct3  = f3;
        i_addr    = addr;
        i_wdata   = wdata;
    endtask

    // Ticks until o_rsp_vld, returning the number of cycles waited (-1 on budget expiry).
    task automatic wait_rsp(input string name, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (o_rsp_vld) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: no response within %0d cycles", name, budget);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  k;
        int  wcnt;
        bit  seen;
        string t;
        t = $sformatf("v%0d", idx);
        model_en   = 1'b1;
        model_dly  = v.dly;
        model_data = v.ld;
        apply_req(v.we, v.f3, v.addr, v.wdata);
        #1;
        chk({t, ".rdy_before"}, 32'(o_req_rdy), 32'd1);
        tick();
        i_req_vld = 1'b0;
        k = 1;
        wcnt = 0;
        seen = 1'b0;
        while (!seen && k <= 20) begin
            #1;
            if (o_lsu_wren) wcnt++;
            if (k == 1) begin
                chk({t, ".bus_addr"}, o_lsu_addr, v.baddr);
                chk({t, ".bus_strb"}, 32'(o_st_strb), 32'(v.strb));
                chk({t, ".bus_wren"}, 32'(o_lsu_wren), 32'(v.we && v.err == 2'b00));
                if (v.we) chk({t, ".bus_data"}, o_st_data, v.sdata);
            end else if (!o_rsp_vld && !v.we) begin
                chk({t, ".wait_addr_hold"}, o_lsu_addr, v.baddr);
            end
            if (o_rsp_vld) begin
                seen = 1'b1;
                chk({t, ".latency"}, 32'(k), 32'(v.lat));
                chk({t, ".err"}, 32'(o_rsp_err), 32'(v.err));
                chk({t, ".rdata"}, o_rsp_rdata, v.rdata);
                chk({t, ".rdy_at_rsp"}, 32'(o_req_rdy), 32'd1);
                chk({t, ".bus_idle_at_rsp"}, o_lsu_addr, 32'd0);
            end else begin
                tick();
                k++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL %s.rsp_budget: no response within 20 cycles", t);
        end
        chk({t, ".wren_cycles"}, 32'(wcnt), 32'(v.we && v.err == 2'b00));
        tick();
        chk({t, ".rsp_single_pulse"}, 32'(o_rsp_vld), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        vec_t sw_after_rst;

        //          we    f3    addr          wdata         ld            dly lat err    rdata         baddr         strb     sdata
        vecs[0]  = '{1'b1, 3'd0, 32'h00002001, 32'h000000A5, 32'h0,        0,  2,  2'b00, 32'h0,        32'h00002000, 4'b0010, 32'hA5A5A5A5};
        vecs[1]  = '{1'b0, 3'd0, 32'h00002001, 32'h0,        32'h00008000, 0,  3,  2'b00, 32'hFFFFFF80, 32'h00002000, 4'b0000, 32'h0};
        vecs[2]  = '{1'b0, 3'd4, 32'h00002001, 32'h0,        32'h00008000, 0,  3,  2'b00, 32'h00000080, 32'h00002000, 4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 3'd5, 32'h00007802, 32'h0,        32'hBEEF1234, 0,  3,  2'b00, 32'h0000BEEF, 32'h00007800, 4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 3'd1, 32'h00007802, 32'h0,        32'h7FFF0000, 2,  5,  2'b00, 32'h00007FFF, 32'h00007800, 4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 3'd2, 32'h00002002, 32'h0,        32'h12345678, 0,  1,  2'b01, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[6]  = '{1'b0, 3'd3, 32'h00002000, 32'h0,        32'h12345678, 0,  1,  2'b11, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 3'd1, 32'h00003002, 32'h1234ABCD, 32'h0,        0,  2,  2'b00, 32'h0,        32'h00003000, 4'b1100, 32'hABCDABCD};
        vecs[8]  = '{1'b1, 3'd2, 32'h00004000, 32'hDEADBEEF, 32'h0,        0,  2,  2'b00, 32'h0,        32'h00004000, 4'b1111, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 3'd2, 32'h00004000, 32'h0,        32'hCAFEF00D, 1,  4,  2'b00, 32'hCAFEF00D, 32'h00004000, 4'b0000, 32'h0};
        vecs[10] = '{1'b1, 3'd4, 32'h00004000, 32'h55555555, 32'h0,        0,  1,  2'b11, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[11] = '{1'b0, 3'd1, 32'h00001003, 32'h0,        32'hFFFFFFFF, 0,  1,  2'b01, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[12] = '{1'b0, 3'd0, 32'h00005003, 32'h0,        32'h7F123456, 0,  3,  2'b00, 32'h0000007F, 32'h00005000, 4'b0000, 32'h0};
        vecs[13] = '{1'b1, 3'd1, 32'h00003001, 32'h0000BEEF, 32'h0,        0,  1,  2'b01, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[14] = '{1'b0, 3'd6, 32'h00000000, 32'h0,        32'h0,        0,  1,  2'b11, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[15] = '{1'b0, 3'd1, 32'h00006002, 32'h0,        32'h80001234, 0,  3,  2'b00, 32'hFFFF8000, 32'h00006000, 4'b0000, 32'h0};
        vecs[16] = '{1'b0, 3'd0, 32'h00006000, 32'h0,        32'h123456FF, 0,  3,  2'b00, 32'hFFFFFFFF, 32'h00006000, 4'b0000, 32'h0};
        vecs[17] = '{1'b1, 3'd0, 32'h00006003, 32'h12345678, 32'h0,        0,  2,  2'b00, 32'h0,        32'h00006000, 4'b1000, 32'h78787878};
        vecs[18] = '{1'b0, 3'd5, 32'h00009000, 32'h0,        32'h0000F00F, 0,  3,  2'b00, 32'h0000F00F, 32'h00009000, 4'b0000, 32'h0};

        // Reset state
        repeat (3) tick();
        i_rst = 1'b0;
        #1;
        chk("rst.rdy", 32'(o_req_rdy), 32'd1);
        chk("rst.rsp_vld", 32'(o_rsp_vld), 32'd0);
        chk("rst.rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst.rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst.lsu_addr", o_lsu_addr, 32'd0);
        chk("rst.st_data", o_st_data, 32'd0);
        chk("rst.st_strb", 32'(o_st_strb), 32'd0);
        chk("rst.wren", 32'(o_lsu_wren), 32'd0);
        tick();

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Load to an address that never answers
        model_en = 1'b0;
        apply_req(1'b0, 3'd2, 32'h00007FF0, 32'h0);
        tick();
        i_req_vld = 1'b0;
`ifdef LSU_REQ_TIMEOUT_EN
        wait_rsp("tmo.rsp", 20, lat);
        chk("tmo.latency", 32'(lat), 32'(2 + TMO));
        chk("tmo.err", 32'(o_rsp_err), 32'd2);
        chk("tmo.rdata", o_rsp_rdata, 32'd0);
        chk("tmo.rdy", 32'(o_req_rdy), 32'd1);
        tick();
        chk("tmo.rsp_single_pulse", 32'(o_rsp_vld), 32'd0);
`else
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (o_rsp_vld) pulses++;
        end
        chk("nowait.no_rsp", 32'(pulses), 32'd0);
        chk("nowait.rdy_low", 32'(o_req_rdy), 32'd0);
        chk("nowait.addr_hold", o_lsu_addr, 32'h00007FF0);
        model_data = 32'h11223344;
        model_dly  = 0;
        model_en   = 1'b1;
        wait_rsp("nowait.rsp", 6, lat);
        chk("nowait.err", 32'(o_rsp_err), 32'd0);
        chk("nowait.rdata", o_rsp_rdata, 32'h11223344);
        tick();
`endif

        // Reset while in WAIT abandons the load silently
        model_en = 1'b0;
        apply_req(1'b0, 3'd2, 32'h00006000, 32'h0);
        tick();
        i_req_vld = 1'b0;
        tick();
        chk("rstwait.in_wait_addr", o_lsu_addr, 32'h00006000);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rstwait.rdy", 32'(o_req_rdy), 32'd1);
        chk("rstwait.bus_addr", o_lsu_addr, 32'd0);
        chk("rstwait.rsp_vld", 32'(o_rsp_vld), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_rsp_vld) pulses++;
        end
        chk("rstwait.no_rsp_after", 32'(pulses), 32'd0);
        sw_after_rst = '{1'b1, 3'd2, 32'h00007000, 32'h12345678, 32'h0, 0, 2, 2'b00,
                         32'h0, 32'h00007000, 4'hF, 32'h12345678};
        run_vec(100, sw_after_rst);

        // Accept in the response cycle; requests outside IDLE are dropped
        apply_req(1'b0, 3'd7, 32'h00000100, 32'h0);
        tick();
        chk("b2b.err_rsp", 32'(o_rsp_vld), 32'd1);
        chk("b2b.err_code", 32'(o_rsp_err), 32'd3);
        chk("b2b.rdy_with_rsp", 32'(o_req_rdy), 32'd1);
        apply_req(1'b1, 3'd2, 32'h00000100, 32'hCAFEBABE);
        tick();
        chk("b2b.issue_wren", 32'(o_lsu_wren), 32'd1);
        chk("b2b.issue_data", o_st_data, 32'hCAFEBABE);
        chk("b2b.issue_rdy", 32'(o_req_rdy), 32'd0);
        apply_req(1'b1, 3'd2, 32'h00000200, 32'h0BADF00D);
        tick();
        i_req_vld = 1'b0;
        chk("b2b.st_rsp", 32'(o_rsp_vld), 32'd1);
        chk("b2b.st_err", 32'(o_rsp_err), 32'd0);
        tick();
        chk("b2b.dropped_wren", 32'(o_lsu_wren), 32'd0);
        chk("b2b.dropped_addr", o_lsu_addr, 32'd0);
        chk("b2b.no_extra_rsp", 32'(o_rsp_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
